// File: rtl/keypad_chord_encoder_if.sv
// Key-pad front-end bundle: raw button lines in, encoded key code and status out.
// The slave modport is the encoder side, the master modport is the button source / consumer.
interface keypad_chord_encoder_if;
    logic [9:0] btn_raw;
    logic [9:0] button;
    logic       button_valid;
    logic       invalid_chord;
    logic       busy;

    modport master (
        output btn_raw,
        input  button,
        input  button_valid,
        input  invalid_chord,
        input  busy
    );

    modport slave (
        input  btn_raw,
        output button,
        output button_valid,
        output invalid_chord,
        output busy
    );
endinterface

// File: rtl/keypad_chord_encoder.sv
// Synchronises and debounces ten push buttons, then merges near-simultaneous presses
// into a single chord code that is presented for exactly one clock per press.
module keypad_chord_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CHORD_CYCLES    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    keypad_chord_encoder_if.slave       kp
);
    localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  CHORD_LAST = 8'(CHORD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RELEASE = 2'd2
    } state_t;

    logic [9:0]  sync1_r;
    logic [9:0]  sync_r;
    logic [9:0]  deb_r;
    logic [15:0] deb_cnt_r [10];
    logic [9:0]  mask_r;
    logic [7:0]  chord_cnt_r;
    state_t      state_r;
    logic [9:0]  button_r;
    logic        button_valid_r;
    logic        invalid_chord_r;
    logic        busy_r;

    state_t      state_s;
    logic [9:0]  mask_s;
    logic [7:0]  chord_cnt_s;
    logic [9:0]  button_s;
    logic        button_valid_s;
    logic        invalid_chord_s;
    logic [9:0]  merged_s;

    // The sixteen codes the calculator understands.
    function automatic logic is_legal(input logic [9:0] m);
        logic ok;
        case (m)
            10'h001, 10'h002, 10'h004, 10'h008, 10'h010,
            10'h020, 10'h040, 10'h080, 10'h100, 10'h200,
            10'h201, 10'h202, 10'h204, 10'h208, 10'h300,
            10'h380: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Two-flop synchroniser on every raw button line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 10'd0;
            sync_r  <= 10'd0;
        end else begin
            sync1_r <= kp.btn_raw;
            sync_r  <= sync1_r;
        end
    end

    // Per-bit debounce: a bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r <= 10'd0;
            for (int i = 0; i < 10; i++) begin
                deb_cnt_r[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (sync_r[i] != deb_r[i]) begin
                    if (deb_cnt_r[i] == DEB_LAST) begin
                        deb_r[i]     <= ~deb_r[i];
                        deb_cnt_r[i] <= 16'd0;
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + 16'd1;
                    end
                end else begin
                    deb_cnt_r[i] <= 16'd0;
                end
            end
        end
    end

    assign merged_s = mask_r | deb_r;

    // Chord FSM next-state and output decode; outputs default low so every code is a single pulse.
    always_comb begin
        state_s         = state_r;
        mask_s          = mask_r;
        chord_cnt_s     = chord_cnt_r;
        button_s        = 10'd0;
        button_valid_s  = 1'b0;
        invalid_chord_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (deb_r != 10'd0) begin
                    mask_s      = deb_r;
                    chord_cnt_s = 8'd0;
                    state_s     = COLLECT;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                mask_s      = merged_s;
                chord_cnt_s = chord_cnt_r + 8'd1;
                if (chord_cnt_r == CHORD_LAST) begin
                    if (is_legal(merged_s)) begin
                        button_s       = merged_s;
                        button_valid_s = 1'b1;
                    end else begin
                        invalid_chord_s = 1'b1;
                    end
                    state_s = RELEASE;
                end else begin
                    state_s = COLLECT;
                end
            end
            RELEASE: begin
                if (deb_r == 10'd0) begin
                    state_s = IDLE;
                end else begin
                    state_s = RELEASE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, chord bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            mask_r          <= 10'd0;
            chord_cnt_r     <= 8'd0;
            button_r        <= 10'd0;
            button_valid_r  <= 1'b0;
            invalid_chord_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_s;
            mask_r          <= mask_s;
            chord_cnt_r     <= chord_cnt_s;
            button_r        <= button_s;
            button_valid_r  <= button_valid_s;
            invalid_chord_r <= invalid_chord_s;
            busy_r          <= (state_s != IDLE);
        end
    end

    assign kp.button        = button_r;
    assign kp.button_valid  = button_valid_r;
    assign kp.invalid_chord = invalid_chord_r;
    assign kp.busy          = busy_r;
endmodule

// File: tb/tb_keypad_chord_encoder.sv
// Directed bench for keypad_chord_encoder with default parameters (14-clock press latency).
module tb_keypad_chord_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    keypad_chord_encoder_if kp_if ();

    keypad_chord_encoder #(
        .DEBOUNCE_CYCLES(4),
        .CHORD_CYCLES   (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (kp_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] press;
        logic [9:0] exp_button;
        logic       exp_invalid;
    } vec_t;

    vec_t vecs [7];

    int         checks   = 0;
    int         failures = 0;
    int         n_btn;
    int         n_inv;
    int         n_busy;
    int         first_btn_i;
    int         first_inv_i;
    logic [9:0] first_btn;
    int         cyc;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic clear_counts();
        n_btn       = 0;
        n_inv       = 0;
        n_busy      = 0;
        first_btn_i = -1;
        first_inv_i = -1;
        first_btn   = 10'd0;
        cyc         = 0;
    endtask

    // Index 0 is the first rising edge after the stimulus was applied.
    task automatic sample_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("valid_vs_button", int'(kp_if.button_valid), int'(kp_if.button != 10'd0));
            if (kp_if.button != 10'd0) begin
                if (first_btn_i < 0) begin
                    first_btn_i = cyc;
                    first_btn   = kp_if.button;
                end
                n_btn++;
            end
            if (kp_if.invalid_chord) begin
                if (first_inv_i < 0) first_inv_i = cyc;
                n_inv++;
            end
            if (kp_if.busy) n_busy++;
            cyc++;
        end
    endtask

    task automatic drive(input logic [9:0] v);
        @(negedge clk);
        kp_if.btn_raw = v;
    endtask

    task automatic release_and_idle(input string name);
        int waited;
        drive(10'd0);
        waited = 0;
        while (kp_if.busy && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check({name, "_busy_idle"}, int'(kp_if.busy), 0);
    endtask

    initial begin
        vecs[0] = '{10'h008, 10'h008, 1'b0};
        vecs[1] = '{10'h001, 10'h001, 1'b0};
        vecs[2] = '{10'h200, 10'h200, 1'b0};
        vecs[3] = '{10'h201, 10'h201, 1'b0};
        vecs[4] = '{10'h006, 10'h000, 1'b1};
        vecs[5] = '{10'h380, 10'h380, 1'b0};
        vecs[6] = '{10'h300, 10'h300, 1'b0};

        // Reset with every button pressed.
        kp_if.btn_raw = 10'h3FF;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_button", int'(kp_if.button), 0);
        check("rst_valid", int'(kp_if.button_valid), 0);
        check("rst_invalid", int'(kp_if.invalid_chord), 0);
        check("rst_busy", int'(kp_if.busy), 0);
        @(negedge clk);
        kp_if.btn_raw = 10'd0;
        rst_n = 1'b1;
        clear_counts();
        sample_cycles(50);
        check("idle_pulses", n_btn, 0);
        check("idle_invalid", n_inv, 0);
        check("idle_busy", n_busy, 0);

        // Table of single presses and chords held for 40 cycles.
        for (int v = 0; v < 7; v++) begin
            clear_counts();
            drive(vecs[v].press);
            sample_cycles(40);
            if (vecs[v].exp_invalid) begin
                check("vec_inv_count", n_inv, 1);
                check("vec_inv_latency", first_inv_i, 14);
                check("vec_inv_no_button", n_btn, 0);
            end else begin
                check("vec_btn_count", n_btn, 1);
                check("vec_btn_value", int'(first_btn), int'(vecs[v].exp_button));
                check("vec_btn_latency", first_btn_i, 14);
                check("vec_no_invalid", n_inv, 0);
            end
            release_and_idle("vec");
        end

        // Bounce: 3-high / 2-low bursts never survive a 4-sample debounce.
        clear_counts();
        for (int r = 0; r < 6; r++) begin
            drive(10'h001);
            sample_cycles(3);
            drive(10'h000);
            sample_cycles(2);
        end
        sample_cycles(10);
        check("bounce_no_pulse", n_btn, 0);
        check("bounce_no_invalid", n_inv, 0);
        check("bounce_no_busy", n_busy, 0);
        clear_counts();
        drive(10'h001);
        sample_cycles(30);
        check("bounce_stable_count", n_btn, 1);
        check("bounce_stable_value", int'(first_btn), 10'h001);
        check("bounce_stable_latency", first_btn_i, 14);
        release_and_idle("bounce");

        // Staggered chord: bit9 first, bit0 five clocks later, merged into '+'.
        clear_counts();
        drive(10'h200);
        sample_cycles(5);
        drive(10'h201);
        sample_cycles(35);
        check("stagger_count", n_btn, 1);
        check("stagger_value", int'(first_btn), 10'h201);
        check("stagger_latency", first_btn_i, 14);
        release_and_idle("stagger");

        // Reset while collecting: nothing emitted, key re-debounced after reset.
        clear_counts();
        drive(10'h004);
        sample_cycles(8);
        check("midrst_busy_before", int'(kp_if.busy), 1);
        check("midrst_no_pulse_before", n_btn, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_button", int'(kp_if.button), 0);
        check("midrst_busy", int'(kp_if.busy), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        sample_cycles(40);
        check("midrst_count", n_btn, 1);
        check("midrst_value", int'(first_btn), 10'h004);
        check("midrst_latency", first_btn_i, 14);
        release_and_idle("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keypad_chord_encoder.md
Name: keypad_chord_encoder

Overview:
- Front-end stage that feeds the calculator FSM's 10-bit `button` input.
- Takes 10 raw, asynchronous, bouncing push-button lines and synchronises and debounces each one.
- Merges near-simultaneous presses into one chord code (e.g. 9+0 = '+', 9+8+7 = Clear).
- Presents each legal code on `button` for exactly one clock per press, so one physical press advances the calculator FSM exactly one step.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before a debounced bit changes. Range 2..65535; 16-bit counter.
- CHORD_CYCLES, 8: length of the chord collection window, in clocks. Range 2..255; 8-bit counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_raw  in  10  raw buttons, active-high; bit i = digit i.
- button  out  10  encoded key code; non-zero for exactly one cycle per accepted press, else 10'b0.
- button_valid  out  1  high in the same cycle `button` is non-zero.
- invalid_chord  out  1  one-cycle pulse when a collected mask is not a legal code.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset:
- rst_n low asynchronously clears the synchronisers, debounced bits, all counters, the mask, `button`, `button_valid`, `invalid_chord` and `busy`.
- FSM goes to IDLE.
- Reset mid-chord or mid-debounce discards everything; no pulse is emitted for that press.
- After release, a still-held key must re-debounce from zero before it is reported.

Synchroniser:
- Two flops per bit; the second stage is `sync`.

Debounce (per bit):
- The counter increments on every edge where sync[i] != deb[i].
- The counter clears to 0 on any edge where they are equal.
- deb[i] toggles on the DEBOUNCE_CYCLES-th consecutive differing edge; the counter clears at the same edge.
- Any pulse shorter than DEBOUNCE_CYCLES clocks after synchronisation is ignored. The same rule applies to release.

FSM (states IDLE, COLLECT, RELEASE):
- IDLE:
  - If deb != 0: mask <= deb, chord_cnt <= 0, go to COLLECT.
- COLLECT:
  - Each edge: mask <= mask | deb, chord_cnt++.
  - On the edge where chord_cnt == CHORD_CYCLES-1:
    - If (mask | deb) is legal: load `button` and set `button_valid`.
    - Otherwise: set `invalid_chord`.
    - Go to RELEASE.
  - Bits released during the window stay in the mask.
- RELEASE:
  - `button`, `button_valid` and `invalid_chord` clear on the first edge in RELEASE, giving a one-cycle pulse.
  - Go to IDLE on the first edge where deb == 0.
  - Keys newly pressed in RELEASE are ignored until all keys are released; no second code is emitted.

Legal codes (exactly 16):
- The ten one-hot digit codes, 10'h001 through 10'h200.
- 10'h201 (+), 10'h202 (-), 10'h204 (*), 10'h208 (/), 10'h300 (=), 10'h380 (Clear).
- Any other non-zero mask is illegal.
- A mask of 0 cannot occur, because entry into COLLECT requires deb != 0.

Latency:
- Raw rising edge sampled at clock edge k → deb high after edge k+1+DEBOUNCE_CYCLES → COLLECT entered at edge k+2+DEBOUNCE_CYCLES → `button` valid after edge k+2+DEBOUNCE_CYCLES+CHORD_CYCLES, held for 1 cycle.
- Defaults: 14 clocks.

Outputs and simultaneous events:
- `busy` is high in COLLECT and RELEASE.
- All outputs are registered; no combinational path from btn_raw.
- Holding a key emits one pulse only; there is no auto-repeat.

Test Plan:
- Reset and idle: hold rst_n=0, btn_raw=10'h3FF → all outputs 0. Release reset with btn_raw=0 → outputs stay 0 and busy=0 for 50 cycles.
- Single digit (defaults): btn_raw=10'h008 stable from edge k, held 40 cycles → button=10'h008 and button_valid=1 for exactly the cycle after edge k+14 → 0 thereafter. After release, busy returns to 0.
- Bounce rejection: btn_raw bit0 toggling with 3-cycle-high / 2-cycle-low bursts → no output. Then stable high for 30 cycles → exactly one button=10'h001 pulse.
- Staggered chord: bit9 rises at edge k, bit0 rises at edge k+5 → single pulse button=10'h201 ('+'). No 10'h200 pulse is ever emitted.
- Illegal chord: bits 1 and 2 pressed together → invalid_chord pulses for 1 cycle, button stays 0. A press of 10'h380 → button=10'h380 (Clear).
- Reset mid-collect: assert rst_n=0 during COLLECT → outputs clear immediately, no pulse. Deassert with the key still held → one pulse 14 clocks after deassert.
